user_module_preamble_tx: RTL and testbench

Serial frame transmitter, the sending end of the "1,0,1" pattern link. The existing combinational detector flags a & ~b & c, i.e. the 1-0-1 marker. This block emits that marker as a serial preamble, then a 4-bit payload (LSB first), then an optional even-parity bit, on a single line.
It sits in the same TinyTapeout user-module slot: 8-bit io_in, 8-bit io_out, clock and reset carried on io_in bits.

---
 rtl/user_module_preamble_tx_pkg.sv | 34 +++
 rtl/user_module_preamble_tx_if.sv | 18 +
 rtl/user_module_preamble_tx_bit_timer.sv | 28 ++
 rtl/user_module_preamble_tx.sv | 147 ++++++++++++++
 tb/tb_user_module_preamble_tx.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/user_module_preamble_tx_pkg.sv
// Shared definitions for the 1-0-1 preamble serial transmitter.
// The package holds the frame states, the marker pattern and the io bit map.
package preamble_tx_pkg;

   localparam int unsigned DATA_W = 4;
   localparam logic [2:0]  PREAMBLE = 3'b101;

   // io_in bit map
   localparam int unsigned CLK_BIT  = 0;
   localparam int unsigned RSTN_BIT = 1;
   localparam int unsigned SEND_BIT = 2;
   localparam int unsigned PAR_BIT  = 3;
   localparam int unsigned DATA_LSB = 4;

   // io_out bit map
   localparam int unsigned TX_BIT   = 0;
   localparam int unsigned BUSY_BIT = 1;
   localparam int unsigned DONE_BIT = 2;
   localparam int unsigned SYNC_BIT = 3;
   localparam int unsigned DQ_LSB   = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      GAP  = 3'd4
   } state_t;

   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/user_module_preamble_tx_if.sv
// Handshake between the frame FSM and its bit timer.
// restart realigns the baud counter at accept; bit_tick marks the last cycle of a bit.
interface user_module_preamble_tx_if;

   logic restart;
   logic bit_tick;

   modport master (
      output restart,
      input  bit_tick
   );

   modport slave (
      input  restart,
      output bit_tick
   );

endinterface

// File: rtl/user_module_preamble_tx_bit_timer.sv
// Baud down-counter: bit_tick is high in the last cycle of each BAUD_DIV-cycle bit.
// Reloads on every bit boundary and on restart, so bit lengths never drift.
module tx_bit_timer #(
   parameter int unsigned BAUD_DIV = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   user_module_preamble_tx_if.slave    tmr
);

   localparam logic [3:0] RELOAD = 4'(BAUD_DIV - 1);

   logic [3:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (tmr.restart || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // A restart cycle is never a bit boundary, whatever the counter holds.
   assign tmr.bit_tick = (r_cnt == '0) && !tmr.restart;

endmodule

// File: rtl/user_module_preamble_tx.sv
// TinyTapeout-slot serial transmitter: 1-0-1 preamble, 4-bit payload LSB first,
// optional even-parity bit and one idle gap bit; all outputs are registered.
module user_module_preamble_tx #(
   parameter logic [2:0]  PREAMBLE = 3'b101,
   parameter int unsigned BAUD_DIV = 1
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   import preamble_tx_pkg::*;

   logic              w_clk;
   logic              w_rst_n;
   logic              w_send;
   logic              w_par_en;
   logic [DATA_W-1:0] w_data;

   assign w_clk    = io_in[CLK_BIT];
   assign w_rst_n  = io_in[RSTN_BIT];
   assign w_send   = io_in[SEND_BIT];
   assign w_par_en = io_in[PAR_BIT];
   assign w_data   = io_in[DATA_LSB +: DATA_W];

   state_t            r_state;
   state_t            w_state_nx;
   logic [1:0]        r_bit;
   logic [1:0]        w_bit_nx;
   logic [DATA_W-1:0] r_data_q;
   logic [DATA_W-1:0] w_data_nx;
   logic              r_par_q;
   logic              w_par_nx;
   logic              r_send_prev;
   logic              r_tx;
   logic              w_tx_nx;
   logic              r_busy;
   logic              r_done;
   logic              r_sync;
   logic              w_accept;
   logic              w_tick;

   user_module_preamble_tx_if tmr_if ();

   assign w_accept       = (r_state == IDLE) && w_send && !r_send_prev;
   assign tmr_if.restart = w_accept;
   assign w_tick         = tmr_if.bit_tick;

   tx_bit_timer #(
      .BAUD_DIV (BAUD_DIV)
   ) u_bit_timer (
      .i_clk   (w_clk),
      .i_rst_n (w_rst_n),
      .tmr     (tmr_if.slave)
   );

   always_comb begin
      w_state_nx = r_state;
      w_bit_nx   = r_bit;
      w_data_nx  = r_data_q;
      w_par_nx   = r_par_q;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nx = PRE;
               w_bit_nx   = '0;
               w_data_nx  = w_data;
               w_par_nx   = w_par_en;
            end
         end
         PRE: begin
            if (w_tick) begin
               if (r_bit == 2'd2) begin
                  w_state_nx = DATA;
                  w_bit_nx   = '0;
               end else begin
                  w_bit_nx = r_bit + 2'd1;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit == 2'(DATA_W - 1)) begin
                  w_state_nx = r_par_q ? PAR : GAP;
                  w_bit_nx   = '0;
               end else begin
                  w_bit_nx = r_bit + 2'd1;
               end
            end
         end
         PAR: begin
            if (w_tick) w_state_nx = GAP;
         end
         GAP: begin
            if (w_tick) w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
            w_bit_nx   = '0;
         end
      endcase
   end

   // tx is computed from the next state so the line changes on the same edge as the state.
   always_comb begin
      w_tx_nx = 1'b0;
      case (w_state_nx)
         PRE:     w_tx_nx = PREAMBLE[2'd2 - w_bit_nx];
         DATA:    w_tx_nx = w_data_nx[w_bit_nx];
         PAR:     w_tx_nx = even_par(w_data_nx);
         default: w_tx_nx = 1'b0;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         r_state     <= IDLE;
         r_bit       <= '0;
         r_data_q    <= '0;
         r_par_q     <= 1'b0;
         r_send_prev <= 1'b1;
         r_tx        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sync      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_bit       <= w_bit_nx;
         r_data_q    <= w_data_nx;
         r_par_q     <= w_par_nx;
         r_send_prev <= w_send;
         r_tx        <= w_tx_nx;
         r_busy      <= (w_state_nx != IDLE);
         r_sync      <= (w_state_nx == PRE);
         r_done      <= (r_state == GAP) && (w_state_nx == IDLE);
      end
   end

   always_comb begin
      io_out                      = '0;
      io_out[TX_BIT]              = r_tx;
      io_out[BUSY_BIT]            = r_busy;
      io_out[DONE_BIT]            = r_done;
      io_out[SYNC_BIT]            = r_sync;
      io_out[DQ_LSB +: DATA_W]    = r_data_q;
   end

endmodule

// File: tb/tb_user_module_preamble_tx.sv
// Directed bench for the preamble transmitter at BAUD_DIV=1 and 2, plus the bit timer.
module tb_user_module_preamble_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       r1, s1, p1;
   logic [3:0] d1;
   logic       r2, s2, p2;
   logic [3:0] d2;
   logic       rt;
   logic [7:0] io_in1, io_out1, io_in2, io_out2;

   assign io_in1 = {d1, p1, s1, r1, clk};
   assign io_in2 = {d2, p2, s2, r2, clk};

   user_module_preamble_tx #(
      .PREAMBLE (3'b101),
      .BAUD_DIV (1)
   ) dut1 (
      .io_in  (io_in1),
      .io_out (io_out1)
   );

   user_module_preamble_tx #(
      .PREAMBLE (3'b101),
      .BAUD_DIV (2)
   ) dut2 (
      .io_in  (io_in2),
      .io_out (io_out2)
   );

   user_module_preamble_tx_if tmr ();

   tx_bit_timer #(
      .BAUD_DIV (3)
   ) u_tmr (
      .i_clk   (clk),
      .i_rst_n (rt),
      .tmr     (tmr.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // io_out layout: {data_q[3:0], sync, done, busy, tx}
   bit e1 [9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   bit e2 [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
   bit e3 [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      r1 = 1'b0; s1 = 1'b1; p1 = 1'b0; d1 = 4'h0;
      r2 = 1'b0; s2 = 1'b1; p2 = 1'b0; d2 = 4'h0;
      rt = 1'b0; tmr.restart = 1'b0;
      repeat (3) step();
      chk("rst_out1", io_out1, 8'h00);
      chk("rst_out2", io_out2, 8'h00);

      // send held high across reset release must not start a frame
      r1 = 1'b1; r2 = 1'b1; rt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("hold_send_c%0d", i), io_out1, 8'h00);
      end

      // bit timer, BAUD_DIV=3
      tmr.restart = 1'b1;
      chk("tmr_restart_mask", {7'd0, tmr.bit_tick}, 8'd0);
      step();
      tmr.restart = 1'b0;
      chk("tmr_c1", {7'd0, tmr.bit_tick}, 8'd0);
      step();
      chk("tmr_c2", {7'd0, tmr.bit_tick}, 8'd0);
      step();
      chk("tmr_c3_tick", {7'd0, tmr.bit_tick}, 8'd1);
      step();
      chk("tmr_reload", {7'd0, tmr.bit_tick}, 8'd0);

      // frame 1: parity, data 1011; send toggles and data changes mid-frame
      s1 = 1'b0;
      step();
      chk("f1_pre_accept", io_out1, 8'h00);
      d1 = 4'b1011; p1 = 1'b1; s1 = 1'b1;
      step();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("f1_c%0d", i + 1), io_out1, {4'b1011, (i < 3), 1'b0, 1'b1, e1[i]});
         s1 = (i % 2 == 1);
         if (i == 2) begin
            d1 = 4'b0100;
            p1 = 1'b0;
         end
         step();
      end
      chk("f1_done", io_out1, 8'b1011_0100);

      // frame 2 accepted in the done cycle: no parity, data 0110
      d1 = 4'b0110; p1 = 1'b0; s1 = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("f2_c%0d", i + 1), io_out1, {4'b0110, (i < 3), 1'b0, 1'b1, e2[i]});
         step();
      end
      chk("f2_c5", io_out1, 8'b0110_0011);

      // reset during DATA aborts with no done pulse
      r1 = 1'b0;
      step();
      chk("midrst", io_out1, 8'h00);
      r1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("post_rst_c%0d", i), io_out1, 8'h00);
      end

      // frame 3 on BAUD_DIV=2 instance: no parity, data 0100
      s2 = 1'b0;
      step();
      chk("f3_pre_accept", io_out2, 8'h00);
      d2 = 4'b0100; p2 = 1'b0; s2 = 1'b1;
      step();
      s2 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("f3_c%0d", i + 1), io_out2, {4'b0100, (i < 6), 1'b0, 1'b1, e3[i]});
         step();
      end
      chk("f3_done", io_out2, 8'b0100_0100);
      step();
      chk("f3_after_done", io_out2, 8'b0100_0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
